mem_access: RTL and testbench

//  MEM stage of the 5-stage RV32I pipeline. It sits between the EX/MEM register and the MEM/WB register.
//  Non-memory instructions pass through combinationally. Loads and stores are serialised over the 8-bit RAM

---
 rtl/mem_access.sv | 144 ++++++++++++++
 tb/tb_mem_access.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM stage: ALU results pass straight through; loads/stores are serialised one byte per cycle
// (little-endian) over an 8-bit RAM port while stall_req_o holds the upstream pipeline.
module mem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rd_addr_i,
  input  logic              rd_write_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [7:0]        mem_din_i,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o,
  output logic              stall_req_o,
  output logic [4:0]        rd_addr_o,
  output logic              rd_write_o,
  output logic [DATA_W-1:0] rd_data_o
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] load_buf;

  logic              is_load;
  logic              is_store;
  logic [2:0]        nbytes;
  logic [ADDR_W-1:0] addr_k;
  logic [1:0]        cap_idx;
  logic [7:0]        store_byte;
  logic [DATA_W-1:0] load_ext;

  assign is_load    = mem_read_i;
  assign is_store   = mem_write_i & ~mem_read_i;
  assign nbytes     = mem_op_i[1] ? 3'd4 : (mem_op_i[0] ? 3'd2 : 3'd1);
  assign addr_k     = mem_addr_i + {{(ADDR_W-3){1'b0}}, cnt};
  assign cap_idx    = cnt[1:0] - 2'd1;
  assign store_byte = mem_wdata_i[{cnt[1:0], 3'b000} +: 8];

  // Bytes of load_buf above the access width may be stale from an earlier load; mask them here.
  always_comb begin
    case (mem_op_i)
      3'b000:  load_ext = {{24{load_buf[7]}}, load_buf[7:0]};
      3'b001:  load_ext = {{16{load_buf[15]}}, load_buf[15:0]};
      3'b100:  load_ext = {24'd0, load_buf[7:0]};
      3'b101:  load_ext = {16'd0, load_buf[15:0]};
      default: load_ext = load_buf;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      load_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_load) begin
            cnt   <= 3'd1;
            state <= LOAD;
          end else if (is_store) begin
            if (nbytes == 3'd1) begin
              state <= DONE;
            end else begin
              cnt   <= 3'd1;
              state <= STORE;
            end
          end
        end
        LOAD: begin
          load_buf[{cap_idx, 3'b000} +: 8] <= mem_din_i;
          if (cnt < nbytes) cnt <= cnt + 3'd1;
          else              state <= DONE;
        end
        STORE: begin
          if (cnt == nbytes - 3'd1) state <= DONE;
          else                      cnt   <= cnt + 3'd1;
        end
        // Return to IDLE unconditionally: the retiring instruction is still on the inputs this cycle.
        DONE: begin
          cnt   <= 3'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_a_o     = '0;
    mem_dout_o  = 8'd0;
    mem_wr_o    = 1'b0;
    stall_req_o = 1'b0;
    rd_addr_o   = 5'd0;
    rd_write_o  = 1'b0;
    rd_data_o   = '0;
    if (rst) begin
      mem_a_o    = mem_addr_i;
      rd_addr_o  = rd_addr_i;
      rd_write_o = rd_write_i;
      rd_data_o  = rd_data_i;
      case (state)
        IDLE: begin
          if (is_load) begin
            stall_req_o = 1'b1;
            rd_write_o  = 1'b0;
          end else if (is_store) begin
            mem_dout_o  = mem_wdata_i[7:0];
            mem_wr_o    = 1'b1;
            stall_req_o = 1'b1;
            rd_write_o  = 1'b0;
          end
        end
        LOAD: begin
          mem_a_o     = addr_k;
          stall_req_o = 1'b1;
          rd_write_o  = 1'b0;
        end
        STORE: begin
          mem_a_o     = addr_k;
          mem_dout_o  = store_byte;
          mem_wr_o    = 1'b1;
          stall_req_o = 1'b1;
          rd_write_o  = 1'b0;
        end
        DONE: begin
          if (is_load)       rd_data_o  = load_ext;
          else if (is_store) rd_write_o = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: byte-wide RAM model, reference model per instruction, scoreboard monitor.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr_i;
  logic        rd_write_i;
  logic [31:0] rd_data_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [2:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [7:0]  mem_din_i;
  logic [31:0] mem_a_o;
  logic [7:0]  mem_dout_o;
  logic        mem_wr_o;
  logic        stall_req_o;
  logic [4:0]  rd_addr_o;
  logic        rd_write_o;
  logic [31:0] rd_data_o;

  mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_i(rd_addr_i), .rd_write_i(rd_write_i), .rd_data_i(rd_data_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_op_i(mem_op_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_din_i(mem_din_i),
    .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o), .mem_wr_o(mem_wr_o),
    .stall_req_o(stall_req_o), .rd_addr_o(rd_addr_o), .rd_write_o(rd_write_o),
    .rd_data_o(rd_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ra;
    logic        rw;
    logic [31:0] rdat;
    bit          chk_d;
    int          stalls;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  logic [7:0] ram     [bit [31:0]];
  logic [7:0] ref_mem [bit [31:0]];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    ram[a]     = d;
    ref_mem[a] = d;
  endtask

  // RAM: synchronous byte write, read data returned one cycle after its address.
  always @(posedge clk) begin
    logic [7:0] rdata;
    rdata = ram_rd(mem_a_o);
    if (rst && mem_wr_o) ram[mem_a_o] = mem_dout_o;
    mem_din_i <= rdata;
  end

  // Monitor: retirements and RAM writes are matched against the queued expectations.
  initial begin
    int stall_cnt;
    exp_t e;
    wr_t  w;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        checks++;
        if (stall_req_o && rd_write_o) begin
          errors++;
          $display("FAIL wr_while_stall: rd_write_o=%b stall_req_o=%b", rd_write_o, stall_req_o);
        end
        if (mem_wr_o) begin
          if (wr_q.size() == 0) begin
            chk("unexpected_write_addr", mem_a_o, 32'hxxxxxxxx);
          end else begin
            w = wr_q.pop_front();
            chk("write_addr", mem_a_o, w.a);
            chk("write_data", {24'd0, mem_dout_o}, {24'd0, w.d});
          end
        end
        if (!mon_en) begin
          stall_cnt = 0;
        end else if (stall_req_o) begin
          stall_cnt++;
        end else if (exp_q.size() == 0) begin
          chk("unexpected_retire", {27'd0, rd_addr_o}, 32'hxxxxxxxx);
        end else begin
          e = exp_q.pop_front();
          chk("stall_cycles", stall_cnt, e.stalls);
          chk("rd_addr", {27'd0, rd_addr_o}, {27'd0, e.ra});
          chk("rd_write", {31'd0, rd_write_o}, {31'd0, e.rw});
          if (e.chk_d) chk("rd_data", rd_data_o, e.rdat);
          stall_cnt = 0;
        end
      end
    end
  end

  // Reference model: derive the architectural result of one instruction, then drive it and
  // hold it until the DUT retires it.
  task automatic issue(input logic [4:0] ra, input logic rw, input logic [31:0] rdat,
                       input logic mr, input logic mw, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int   n;
    logic [31:0] v;
    n = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    e.ra = ra;
    if (mr) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | ({24'd0, ref_rd(addr + i)} << (8 * i));
      if (op == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
      if (op == 3'b001 && v[15]) v = v | 32'hFFFF0000;
      e.rw = rw; e.rdat = v; e.chk_d = 1'b1; e.stalls = n + 1;
    end else if (mw) begin
      for (int i = 0; i < n; i++) begin
        wr_t w;
        w.a = addr + i;
        w.d = 8'((wd >> (8 * i)) & 32'hFF);
        wr_q.push_back(w);
        ref_mem[w.a] = w.d;
      end
      e.rw = 1'b0; e.rdat = rdat; e.chk_d = 1'b0; e.stalls = n;
    end else begin
      e.rw = rw; e.rdat = rdat; e.chk_d = 1'b1; e.stalls = 0;
    end
    exp_q.push_back(e);
    rd_addr_i = ra; rd_write_i = rw; rd_data_i = rdat;
    mem_read_i = mr; mem_write_i = mw; mem_op_i = op;
    mem_addr_i = addr; mem_wdata_i = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall_req_o && n < 20);
    if (stall_req_o) begin
      errors++;
      $display("FAIL retire_timeout: stall_req_o still %b after %0d cycles", stall_req_o, n);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    int kind;
    rst = 1'b0;
    rd_addr_i = 5'd7; rd_write_i = 1'b1; rd_data_i = 32'hDEADBEEF;
    mem_read_i = 1'b0; mem_write_i = 1'b1; mem_op_i = 3'b010;
    mem_addr_i = 32'h55; mem_wdata_i = 32'h12345678;
    repeat (2) @(negedge clk);
    chk("reset_mem_wr", {31'd0, mem_wr_o}, 32'd0);
    chk("reset_stall", {31'd0, stall_req_o}, 32'd0);
    chk("reset_rd_write", {31'd0, rd_write_o}, 32'd0);
    chk("reset_mem_a", mem_a_o, 32'd0);
    chk("reset_rd_data", rd_data_o, 32'd0);
    mem_write_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;

    issue(5'd5, 1'b1, 32'h1234, 1'b0, 1'b0, 3'b000, 32'h40, 32'h0);
    poke(32'h100, 8'h80);
    issue(5'd1, 1'b1, 32'h0, 1'b1, 1'b0, 3'b000, 32'h100, 32'h0);
    issue(5'd2, 1'b1, 32'h0, 1'b1, 1'b0, 3'b100, 32'h100, 32'h0);
    poke(32'h103, 8'h11); poke(32'h104, 8'h22); poke(32'h105, 8'h33); poke(32'h106, 8'h44);
    issue(5'd3, 1'b1, 32'h0, 1'b1, 1'b0, 3'b010, 32'h103, 32'h0);
    issue(5'd4, 1'b1, 32'h0, 1'b0, 1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000ABCD);
    chk("sh_byte_ffffffff", {24'd0, ram_rd(32'hFFFFFFFF)}, 32'hCD);
    chk("sh_byte_00000000", {24'd0, ram_rd(32'h0)}, 32'hAB);
    issue(5'd6, 1'b1, 32'h0, 1'b1, 1'b0, 3'b010, 32'h103, 32'h0);
    issue(5'd8, 1'b1, 32'h0, 1'b0, 1'b1, 3'b000, 32'h110, 32'h000000E7);
    issue(5'd9, 1'b1, 32'h0, 1'b1, 1'b1, 3'b101, 32'h104, 32'hFFFFFFFF);

    // Reset in the middle of a word store: only the first two bytes may land.
    mon_en = 1'b0;
    begin
      wr_t w;
      w.a = 32'h300; w.d = 8'h0D; wr_q.push_back(w);
      w.a = 32'h301; w.d = 8'h0C; wr_q.push_back(w);
    end
    ref_mem[32'h300] = 8'h0D; ref_mem[32'h301] = 8'h0C;
    rd_addr_i = 5'd10; rd_write_i = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b1;
    mem_op_i = 3'b010; mem_addr_i = 32'h300; mem_wdata_i = 32'h0A0B0C0D;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_store_wr", {31'd0, mem_wr_o}, 32'd0);
    chk("rst_mid_store_stall", {31'd0, stall_req_o}, 32'd0);
    mem_write_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", {31'd0, stall_req_o}, 32'd0);
    chk("post_rst_byte2", {24'd0, ram_rd(32'h302)}, {24'd0, dflt(32'h302)});
    chk("post_rst_byte3", {24'd0, ram_rd(32'h303)}, {24'd0, dflt(32'h303)});
    chk("post_rst_byte1", {24'd0, ram_rd(32'h301)}, 32'h0C);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 3);
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3)
                                      : 32'h200 + $urandom_range(0, 31);
      issue(5'($urandom), 1'($urandom), $urandom, kind[0], kind[1] | (kind == 0 ? 1'b0 : 1'b0),
            3'($urandom), a, $urandom);
    end

    chk("exp_queue_drained", exp_q.size(), 0);
    chk("write_queue_drained", wr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
